// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider bank: default sizing, the
// channel-index width helper and the configuration request record.
package clkdiv_pkg;

  localparam int CNT_W_DEF    = 25;
  localparam int DEF_HALF_DEF = 25_000_000;

  // Widest channel index (16 channels) and widest counter the request
  // record has to carry; the bank zero-extends its ports into these fields.
  localparam int CH_MAX_W  = 4;
  localparam int CNT_MAX_W = 32;

  // Channel-select width, never below one bit so a single-channel bank
  // still has a legal port.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef struct packed {
    logic [CH_MAX_W-1:0]  ch;
    logic [CNT_MAX_W-1:0] half;
    logic                 imm;
  } cfg_req_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active and shadow half-period, pending
// flag, the registered square output and its toggle tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load_imm,
  input  logic             load_def,
  input  logic [CNT_W-1:0] load_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] shadow;
  logic             wrap;

  // Last count of the current half-period; half is never zero, so the
  // subtraction cannot underflow.
  assign wrap = (cnt == half - CNT_W'(1));

  // Counter, half-period bookkeeping and output registers.
  // NOTE: every register here uses <= so all of them see the pre-edge
  // values of cnt/half/pending no matter in which order they are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      half    <= CNT_W'(DEF_HALF);
      shadow  <= CNT_W'(DEF_HALF);
      pending <= 1'b0;
      clk_out <= 1'b1;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load_imm) begin
        // An immediate load restarts the channel high, whether or not a
        // sync arrives on the same edge.
        half    <= load_val;
        cnt     <= '0;
        clk_out <= 1'b1;
      end else if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b1;
        if (pending) begin
          half    <= shadow;
          pending <= 1'b0;
        end
      end else if (en) begin
        if (wrap) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
          if (pending) begin
            half    <= shadow;
            pending <= 1'b0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A deferred request is only accepted while nothing is pending, so
      // this never overwrites a shadow that the branches above consume.
      if (load_def) begin
        shadow  <= load_val;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of independent clock dividers sharing one configuration port and a
// global re-phase strobe.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  input  logic                    cfg_imm,
  output logic                    cfg_err,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  localparam int CH_W = ch_w(NUM_CH);

  cfg_req_t          req;
  logic              ch_ok;
  logic              legal;
  logic              accept;
  logic [CNT_W-1:0]  load_val;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load_imm;
  logic [NUM_CH-1:0] load_def;

  // Request decode: legality, handshake and per-channel load strobes.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    req      = '{ch: CH_MAX_W'(cfg_ch), half: CNT_MAX_W'(cfg_half), imm: cfg_imm};
    ch_ok    = (32'(req.ch) < NUM_CH);
    legal    = ch_ok && (req.half != '0);
    load_val = req.half[CNT_W-1:0];
    // Channels that do not exist have nothing pending, so a request to one
    // is always taken and then flagged as an error.
    cfg_ready = 1'b1;
    if (ch_ok) begin
      cfg_ready = ~pending[req.ch[CH_W-1:0]];
    end
    accept   = cfg_valid && cfg_ready;
    load_imm = '0;
    load_def = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && legal && (32'(req.ch) == i)) begin
        load_imm[i] = req.imm;
        load_def[i] = ~req.imm;
      end
    end
  end

  // One-cycle error pulse for an accepted but illegal request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && !legal;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .sync     (sync),
      .load_imm (load_imm[i]),
      .load_def (load_def[i]),
      .load_val (load_val),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Scoreboard bench for clkdiv_bank: scenarios push the ticks and error
// pulses they expect; a monitor pops and compares whenever one appears.
module tb_clkdiv_bank;
  import clkdiv_pkg::*;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 5;
  localparam int CH_W     = ch_w(NUM_CH);

  typedef struct {
    int   cyc;
    logic val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              sync = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic              cfg_imm = 1'b0;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int   cyc;
  int   checks = 0;
  int   errors = 0;
  exp_t tq[NUM_CH][$];
  int   eq[$];

  clkdiv_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_imm   (cfg_imm),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Edge counter: edge 1 is the first rising edge after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick and every error pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick[c]) begin
          check($sformatf("tick expected on ch%0d", c), int'(tq[c].size() != 0), 1);
          if (tq[c].size() != 0) begin
            exp_t e;
            e = tq[c].pop_front();
            check($sformatf("tick edge ch%0d", c), cyc, e.cyc);
            check($sformatf("clk_out at tick ch%0d", c), int'(clk_out[c]), int'(e.val));
          end
        end
      end
      if (cfg_err) begin
        check("cfg_err expected", int'(eq.size() != 0), 1);
        if (eq.size() != 0) check("cfg_err edge", cyc, eq.pop_front());
      end
    end
  end

  // Return just after edge k-1 so inputs driven now take effect at edge k.
  task automatic goto(input int k);
    int guard = 0;
    while (cyc != k - 1) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 500) begin
        $display("FAIL goto: edge %0d never reached, at %0d", k, cyc);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_imm = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic cfg_at(input int k, input int ch, input int half, input logic imm);
    goto(k);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_half = CNT_W'(half); cfg_imm = imm;
    goto(k + 1);
    cfg_valid = 1'b0; cfg_half = '0; cfg_imm = 1'b0;
  endtask

  task automatic exp_run(input int ch, input int first, input int half, input int n, input logic v0);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = first + k * half;
      e.val = v0 ^ logic'(k[0]);
      tq[ch].push_back(e);
    end
  endtask

  // Disable all channels before edge stop and confirm every expectation was met.
  task automatic finish_scn(input int stop);
    goto(stop);
    en = '0;
    goto(stop + 2);
    for (int c = 0; c < NUM_CH; c++) check($sformatf("ch%0d events left", c), tq[c].size(), 0);
    check("cfg_err events left", eq.size(), 0);
  endtask

  initial begin
    // Scenario 1: reset state and default half-period timing.
    do_reset();
    check("reset clk_out", int'(clk_out), 7);
    check("reset tick", int'(tick), 0);
    check("reset cfg_err", int'(cfg_err), 0);
    check("reset cfg_ready", int'(cfg_ready), 1);
    en = 3'b001;
    exp_run(0, 5, 5, 3, 1'b0);
    finish_scn(16);
    check("clk_out held with en=0", int'(clk_out), 6);

    // Scenario 2: deferred load on ch1 waits for the current period to end.
    do_reset();
    en = 3'b010;
    exp_run(1, 5, 5, 1, 1'b0);
    exp_run(1, 8, 3, 3, 1'b1);
    cfg_at(3, 1, 3, 1'b0);
    check("ch1 ready while pending", int'(cfg_ready), 0);
    cfg_ch = 2'd0;
    #1 check("ch0 ready while ch1 pending", int'(cfg_ready), 1);
    cfg_ch = 2'd1;
    goto(5);
    check("ch1 ready before wrap", int'(cfg_ready), 0);
    goto(6);
    check("ch1 ready after wrap", int'(cfg_ready), 1);
    finish_scn(15);

    // Scenario 3: immediate loads restart the channel high with no tick.
    do_reset();
    en = 3'b101;
    exp_run(0, 5, 5, 1, 1'b0);
    exp_run(0, 11, 4, 2, 1'b0);
    exp_run(2, 6, 2, 5, 1'b0);
    cfg_at(4, 2, 2, 1'b1);
    check("ch2 high after imm load", int'(clk_out[2]), 1);
    goto(7);
    check("ch0 low before imm load", int'(clk_out[0]), 0);
    cfg_at(7, 0, 4, 1'b1);
    check("ch0 high after imm load", int'(clk_out[0]), 1);
    finish_scn(16);

    // Scenario 4: illegal requests pulse cfg_err and leave channels alone.
    do_reset();
    en = 3'b111;
    for (int c = 0; c < NUM_CH; c++) exp_run(c, 5, 5, 2, 1'b0);
    eq.push_back(2); eq.push_back(4); eq.push_back(6);
    cfg_at(2, 0, 0, 1'b1);
    goto(4);
    cfg_ch = 2'd3;
    #1 check("ready for absent channel", int'(cfg_ready), 1);
    cfg_at(4, 3, 4, 1'b1);
    cfg_at(6, 1, 0, 1'b0);
    cfg_ch = 2'd1;
    #1 check("no pending from illegal deferred", int'(cfg_ready), 1);
    finish_scn(11);

    // Scenario 5: sync re-phases all channels and applies a pending load.
    do_reset();
    en = 3'b111;
    exp_run(0, 5, 5, 1, 1'b0);
    exp_run(0, 12, 5, 2, 1'b0);
    exp_run(1, 12, 5, 2, 1'b0);
    exp_run(2, 5, 5, 1, 1'b0);
    exp_run(2, 10, 3, 4, 1'b0);
    cfg_at(3, 1, 5, 1'b1);
    cfg_at(6, 2, 3, 1'b0);
    goto(7);
    check("phases before sync", int'(clk_out), 2);
    check("ch2 pending before sync", int'(cfg_ready), 0);
    sync = 1'b1;
    goto(8);
    sync = 1'b0;
    check("clk_out after sync", int'(clk_out), 7);
    check("ch2 ready after sync", int'(cfg_ready), 1);
    finish_scn(20);

    // Scenario 6: asynchronous reset mid-count, then default timing again.
    do_reset();
    en = 3'b001;
    exp_run(0, 5, 5, 1, 1'b0);
    goto(8);
    check("ch0 low before async reset", int'(clk_out[0]), 0);
    #2 rst_n = 1'b0;
    #1 check("clk_out in async reset", int'(clk_out), 7);
    check("tick in async reset", int'(tick), 0);
    check("ch0 events before reset", tq[0].size(), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_run(0, 5, 5, 3, 1'b0);
    finish_scn(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
